// File: rtl/env_sweep_scheduler.sv
// env_sweep_scheduler: per game_tick, sweeps every grid cell issuing 9 toroidal neighbourhood lookups then one write strobe
module env_sweep_scheduler #(
  parameter int X_bits = 8,
  parameter int Y_bits = 7,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119
) (
  input  logic              newLocClock,
  input  logic              RESET_SIM,
  input  logic              RUN,
  input  logic              PAUSE,
  input  logic              game_tick,
  output logic [X_bits-1:0] view_x,
  output logic [Y_bits-1:0] view_y,
  output logic              nbr_valid,
  output logic [3:0]        nbr_idx,
  output logic [X_bits-1:0] write_x,
  output logic [Y_bits-1:0] write_y,
  output logic              write_flag,
  output logic              busy,
  output logic              sweep_done,
  output logic              overrun
);
  localparam logic [X_bits-1:0] XM = X_bits'(X_MAX);
  localparam logic [Y_bits-1:0] YM = Y_bits'(Y_MAX);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, PAUSED, DONE} state_t;
  state_t state, state_n;
  logic [3:0] k, k_n;
  logic [X_bits-1:0] cx, cx_n, xm, xp;
  logic [Y_bits-1:0] cy, cy_n, ym, yp;
  logic start, rd;
  assign start = game_tick & RUN & ~PAUSE;
  assign rd = state == READ;
  assign xm = cx == '0 ? XM : cx - 1'b1;
  assign xp = cx == XM ? '0 : cx + 1'b1;
  assign ym = cy == '0 ? YM : cy - 1'b1;
  assign yp = cy == YM ? '0 : cy + 1'b1;
  assign view_x = rd && k inside {4'd1, 4'd2, 4'd3} ? xp : rd && k inside {4'd5, 4'd6, 4'd7} ? xm : cx;
  assign view_y = rd && k inside {4'd0, 4'd1, 4'd7} ? ym : rd && k inside {4'd3, 4'd4, 4'd5} ? yp : cy;
  assign write_x = cx;
  assign write_y = cy;
  assign write_flag = state == WRITE;
  assign busy = state != IDLE;
  assign sweep_done = state == DONE;
  always_comb begin
    state_n = state;
    k_n = k;
    cx_n = cx;
    cy_n = cy;
    unique case (state)
      IDLE: if (start) begin
        state_n = READ;
        k_n = '0;
        cx_n = '0;
        cy_n = '0;
      end
      READ: begin
        k_n = k == 4'd8 ? '0 : k + 4'd1;
        state_n = k == 4'd8 ? WAIT : READ;
      end
      WAIT: state_n = WRITE;
      WRITE: begin
        k_n = '0;
        cx_n = xp;
        cy_n = cx == XM ? yp : cy;
        state_n = cx == XM && cy == YM ? DONE : PAUSE ? PAUSED : READ;
      end
      PAUSED: state_n = PAUSE ? PAUSED : READ;
      DONE: state_n = start ? READ : IDLE;
      default: state_n = IDLE;
    endcase
    if (!RUN) begin
      state_n = IDLE;
      k_n = '0;
      cx_n = '0;
      cy_n = '0;
    end
  end
  always_ff @(posedge newLocClock) begin
    if (RESET_SIM) begin
      state <= IDLE;
      k <= '0;
      cx <= '0;
      cy <= '0;
      nbr_valid <= 1'b0;
      nbr_idx <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      k <= k_n;
      cx <= cx_n;
      cy <= cy_n;
      nbr_valid <= rd & RUN;
      nbr_idx <= rd && RUN ? k : '0;
      overrun <= overrun | (game_tick & busy & ~sweep_done);
    end
  end
endmodule
